simple_uart_rx: RTL and testbench

- Serial 8N1 UART receiver: the receive-side counterpart of simpleUARTtx, consuming the `serial` line it drives.
- Runs on the 24 MHz system clock with 16x oversampling derived internally, so it needs no external baud clock.
- Delivers each received byte as a parallel word with a one-cycle valid strobe, plus framing-error and busy indications.
- Used for loopback tests against the TX path and as the input stage for host-to-FPGA commands.

---
 rtl/simple_uart_rx.sv | 176 +++++++++++++++++
 tb/tb_simple_uart_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/simple_uart_rx.sv
// 8N1 UART receiver with 16x oversampling derived from the system clock.
// Define SIMPLE_UART_RX_PARITY_EN for 8E1 framing with a parity_err output.
module simple_uart_rx #(
    parameter int unsigned CLK_HZ = 24000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned OSR    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
`ifdef SIMPLE_UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned DIV = CLK_HZ / (BAUD * OSR);
    localparam int unsigned TW  = $clog2(DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [3:0]    OS_MID    = 4'(OSR / 2 - 1);
    localparam logic [3:0]    OS_LAST   = 4'(OSR - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_e;

    state_e          state_q, state_d;
    logic            sync_q, rx_s;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]      os_q, os_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;
    logic            busy_q, busy_d;
    logic            tick;
    logic            par_bad;
`ifdef SIMPLE_UART_RX_PARITY_EN
    logic            parity_q, parity_d;
    logic            parity_err_q, parity_err_d;
`endif

    assign tick = (state_q != StIdle) && (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d     = state_q;
        os_d        = os_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        par_bad     = 1'b0;
`ifdef SIMPLE_UART_RX_PARITY_EN
        parity_d     = parity_q;
        parity_err_d = 1'b0;
        par_bad      = ^shift_q ^ parity_q;
`endif
        // Held at zero while idle so ticks line up with the start-bit edge.
        if (state_q == StIdle || tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
        if (tick) begin
            os_d = (os_q == OS_LAST) ? 4'd0 : os_q + 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (tick && os_q == OS_MID) begin
                    state_d   = rx_s ? StIdle : StData;
                    bit_cnt_d = 3'd0;
                end
            end
            StData: begin
                if (tick && os_q == OS_LAST) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef SIMPLE_UART_RX_PARITY_EN
                    if (bit_cnt_q == 3'd7) state_d = StParity;
`else
                    if (bit_cnt_q == 3'd7) state_d = StStop;
`endif
                end
            end
            StParity: begin
`ifdef SIMPLE_UART_RX_PARITY_EN
                if (tick && os_q == OS_LAST) begin
                    parity_d = rx_s;
                    state_d  = StStop;
                end
`else
                state_d = StIdle;
`endif
            end
            StStop: begin
                if (tick && os_q == OS_LAST) begin
`ifdef SIMPLE_UART_RX_PARITY_EN
                    parity_err_d = par_bad;
`endif
                    if (rx_s) begin
                        state_d = StIdle;
                        if (!par_bad) begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) os_d = 4'd0;
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 1'b1;
            rx_s        <= 1'b1;
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            os_q        <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= line;
            rx_s        <= sync_q;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            os_q        <= os_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SIMPLE_UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_simple_uart_rx.sv
// Scoreboard bench for simple_uart_rx: frames are built from their bit-level
// definition, expected events are queued and matched by a separate monitor.
module tb_simple_uart_rx;

    localparam int BIT = 208;  // 13 clk per tick * 16 ticks

    logic       clk = 1'b0;
    logic       rst;
    logic       line;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic       perr_obs;

`ifdef SIMPLE_UART_RX_PARITY_EN
    logic parity_err;
    assign perr_obs = parity_err;
`else
    assign perr_obs = 1'b0;
`endif

    simple_uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .line      (line),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
`ifdef SIMPLE_UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    logic busy_mid = 1'b0;
    logic [7:0] last_good = 8'h00;

    // kind: 0 = good byte, 1 = framing error, 2 = parity error
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;
    ev_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v, input int nbits);
        line = v;
        wait_clk(nbits * BIT);
    endtask

    // stop_low > 0 holds the stop bit low for that many bit times.
    task automatic send_frame(input logic [7:0] b, input logic par_ok, input int stop_low);
        start_cyc = cyc;
        send_bit(1'b0, 1);
        busy_mid = busy;
        for (int i = 0; i < 8; i++) send_bit(b[i], 1);
`ifdef SIMPLE_UART_RX_PARITY_EN
        send_bit(^b ^ ~par_ok, 1);
`endif
        if (stop_low > 0) begin
            send_bit(1'b0, stop_low);
            line = 1'b1;
        end else begin
            send_bit(1'b1, 1);
        end
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back('{kind: 2'd0, data: b});
        last_good = b;
        send_frame(b, 1'b1, 0);
    endtask

    task automatic send_ferr(input logic [7:0] b, input int stop_low);
        exp_q.push_back('{kind: 2'd1, data: last_good});
        send_frame(b, 1'b1, stop_low);
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && frame_err) check("valid_ferr_exclusive", 1, 0);
            if (valid || frame_err || perr_obs) begin
                int kind;
                ev_t e;
                kind = valid ? 0 : (frame_err ? 1 : 2);
                if (valid) valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: kind %0d data 0x%02h, none expected",
                             kind, data);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", kind, int'(e.kind));
                    check("event_data", int'(data), int'(e.data));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst  = 1'b1;
        line = 1'b1;
        wait_clk(5);
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        wait_clk(20);

        // Single byte, with latency and busy checks
        send_good(8'h55);
        check("busy_mid_frame", int'(busy_mid), 1);
        check("valid_latency_ok", int'(valid_cyc - start_cyc >= 1975 &&
                                       valid_cyc - start_cyc <= 1985), 1);
        wait_clk(10);
        check("busy_after_frame", int'(busy), 0);
        wait_clk(BIT);

        // Back-to-back with no idle gap
        send_good(8'h00);
        send_good(8'hFF);
        send_good(8'hA5);
        wait_clk(BIT);

        // Glitch rejection
        line = 1'b0;
        wait_clk(40);
        line = 1'b1;
        n = 0;
        while (busy && n < 104) begin
            wait_clk(1);
            n++;
        end
        check("glitch_busy_release", int'(busy), 0);
        wait_clk(BIT);

        // Framing error with a long low stop, then recovery
        send_ferr(8'h3C, 3);
        wait_clk(BIT);
        check("ferr_data_hold", int'(data), int'(last_good));
        send_good(8'h81);
        wait_clk(BIT);

        // Reset during bit 4 of 0x5A
        begin
            logic [7:0] b;
            b = 8'h5A;
            send_bit(1'b0, 1);
            for (int i = 0; i < 4; i++) send_bit(b[i], 1);
            line = b[4];
            wait_clk(BIT / 2);
            rst = 1'b1;
            #1;
            check("midreset_data", int'(data), 0);
            check("midreset_valid", int'(valid), 0);
            check("midreset_frame_err", int'(frame_err), 0);
            check("midreset_busy", int'(busy), 0);
            last_good = 8'h00;
            wait_clk(5);
            line = 1'b1;
            wait_clk(2);
            rst = 1'b0;
            wait_clk(BIT);
        end
        send_good(8'hC3);
        wait_clk(BIT);

`ifdef SIMPLE_UART_RX_PARITY_EN
        exp_q.push_back('{kind: 2'd0, data: 8'h07});
        last_good = 8'h07;
        send_frame(8'h07, 1'b1, 0);
        exp_q.push_back('{kind: 2'd2, data: last_good});
        send_frame(8'h07, 1'b0, 0);
        wait_clk(BIT);
`endif

        // Random bytes with random idle gaps (often zero)
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            send_good(b);
            if ($urandom_range(0, 2) != 0) wait_clk($urandom_range(1, 400));
        end

        wait_clk(3 * BIT);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
